// File: rtl/elm_hidden_collector_if.sv
// elm_hidden_collector_if
// Groups the hidden-layer capture bus and the serialised output stream of the
// ELM hidden collector.
//   hidden_out    : neuron i activation at [i*IN_WIDTH +: IN_WIDTH]
//   hidden_valid  : bit i = neuron i outvalid (single-cycle pulse per frame)
//   stream_data   : serialised activation word for the output-layer neurons
//   stream_valid  : stream_data valid (next-layer myinputValid)
//   stream_last   : marks the word of index NUM_NEURONS-1
// Modports: master = hidden-layer side / stream consumer, slave = collector.
interface elm_hidden_collector_if #(
  parameter int NUM_NEURONS = 20,
  parameter int IN_WIDTH    = 8,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_NEURONS*IN_WIDTH-1:0] hidden_out;
  logic [NUM_NEURONS-1:0]          hidden_valid;
  logic [DATA_WIDTH-1:0]           stream_data;
  logic                            stream_valid;
  logic                            stream_last;

  modport master (
    output hidden_out, hidden_valid,
    input  stream_data, stream_valid, stream_last
  );

  modport slave (
    input  hidden_out, hidden_valid,
    output stream_data, stream_valid, stream_last
  );
endinterface

// File: rtl/elm_hidden_collector.sv
// elm_hidden_collector
// Captures per-neuron hidden activations into a ping-pong buffer and replays
// each completed hidden vector as a one-word-per-cycle stream, followed by an
// idle gap so the output-layer neurons can detect end-of-vector.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   bus      : elm_hidden_collector_if.slave (hidden capture in, stream out)
//   busy     : a bank is full, the stream FSM is active, or a fill is underway
//   overflow : sticky error flag (duplicate or dropped activation), rst clears
module elm_hidden_collector #(
  parameter int NUM_NEURONS = 20,
  parameter int IN_WIDTH    = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT       = 0,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  elm_hidden_collector_if.slave bus,
  output logic                 busy,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  generate
    if (IN_WIDTH + SHIFT > DATA_WIDTH - 1) begin : g_width_err
      $error("elm_hidden_collector: IN_WIDTH+SHIFT must not exceed DATA_WIDTH-1");
    end
    if (NUM_NEURONS < 2) begin : g_neuron_err
      $error("elm_hidden_collector: NUM_NEURONS must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_gap_err
      $error("elm_hidden_collector: GAP_CYCLES must be >= 1");
    end
  endgenerate

  // Unsigned activation, zero-extended to the stream width then scaled.
  function automatic logic [DATA_WIDTH-1:0] scale_word(input logic [IN_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] w;
    w = DATA_WIDTH'(a);
    return w << SHIFT;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [IN_WIDTH-1:0]           bank_q [2][NUM_NEURONS];
  logic [1:0][NUM_NEURONS-1:0]   mask_q, mask_d;
  logic [1:0]                    full_q, full_d;
  logic                          fill_q, fill_d;
  logic                          strm_q, strm_d;
  logic                          ovf_q, ovf_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [GAP_W-1:0]              gap_q, gap_d;
  logic [NUM_NEURONS-1:0]        wr_en;
  logic                          release_bank;
  logic [DATA_WIDTH-1:0]         sdata_q, sdata_d;
  logic                          svalid_q, svalid_d;
  logic                          slast_q, slast_d;

  // Stream FSM: next state and the word index to present next cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    strm_d       = strm_q;
    release_bank = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[strm_q]) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          release_bank = 1'b1;
          strm_d       = ~strm_q;
          gap_d        = GAP_LOAD;
          state_d      = S_GAP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_ONE) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture into the fill bank and ping-pong bookkeeping. Full flags are
  // only ever read as registered values, so a bank released this edge is
  // not seen as free until the following cycle.
  always_comb begin
    mask_d = mask_q;
    full_d = full_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    wr_en  = '0;
    if (!full_q[fill_q]) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (bus.hidden_valid[i]) begin
          if (mask_q[fill_q][i]) begin
            ovf_d = 1'b1;
          end else begin
            mask_d[fill_q][i] = 1'b1;
            wr_en[i]          = 1'b1;
          end
        end
      end
      if (&mask_d[fill_q]) begin
        full_d[fill_q] = 1'b1;
      end
    end else if (|bus.hidden_valid) begin
      ovf_d = 1'b1;
    end
    if (full_q[fill_q] && !full_q[~fill_q]) begin
      fill_d = ~fill_q;
    end
    // The streaming bank is always full, so it never collides with a capture.
    if (release_bank) begin
      mask_d[strm_q] = '0;
      full_d[strm_q] = 1'b0;
    end
  end

  // Stream outputs are registered from the FSM's next state so they line up
  // with the state register.
  always_comb begin
    svalid_d = (state_d == S_STREAM);
    slast_d  = svalid_d && (idx_d == LAST_IDX);
    sdata_d  = svalid_d ? scale_word(bank_q[strm_q][idx_d]) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      full_q   <= '0;
      fill_q   <= 1'b0;
      strm_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      gap_q    <= '0;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
      sdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      full_q   <= full_d;
      fill_q   <= fill_d;
      strm_q   <= strm_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      svalid_q <= svalid_d;
      slast_q  <= slast_d;
      sdata_q  <= sdata_d;
    end
  end

  // Bank storage carries no reset; the masks decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (wr_en[i]) begin
        bank_q[fill_q][i] <= bus.hidden_out[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  assign bus.stream_data  = sdata_q;
  assign bus.stream_valid = svalid_q;
  assign bus.stream_last  = slast_q;
  assign overflow         = ovf_q;
  assign busy             = (|full_q) | (state_q != S_IDLE) | (|mask_q[fill_q]);

endmodule

// File: tb/tb_elm_hidden_collector.sv
// Testbench for elm_hidden_collector: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a
// frame-level schedule model.
module tb_elm_hidden_collector;
  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int DW  = 16;
  localparam int SH  = 4;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy, overflow;

  always #5 clk = ~clk;

  elm_hidden_collector_if #(.NUM_NEURONS(N), .IN_WIDTH(IW), .DATA_WIDTH(DW)) hif ();

  elm_hidden_collector #(
    .NUM_NEURONS(N), .IN_WIDTH(IW), .DATA_WIDTH(DW), .SHIFT(SH), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(hif),
    .busy(busy),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              cyc;
    logic [DW-1:0]   data;
    bit              last;
  } word_t;

  logic [N-1:0]  m_mask [2];
  bit            m_full [2];
  logic [IW-1:0] m_data [2][N];
  int            free_at [2];
  bit            m_fill, m_ovf, started = 1'b0;
  int            next_start;
  word_t         exp_q[$];
  int            win_s[$], win_e[$];

  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      m_mask[b]  = '0;
      m_full[b]  = 1'b0;
      free_at[b] = -1;
    end
    m_fill     = 1'b0;
    m_ovf      = 1'b0;
    next_start = 0;
    exp_q.delete();
    win_s.delete();
    win_e.delete();
  endtask

  always @(posedge clk) begin : model
    bit    fo0, fo1, fill_full, other_full;
    int    start;
    word_t w;
    if (rst) begin
      m_reset();
      started = 1'b1;
    end else begin
      fo0        = m_full[0];
      fo1        = m_full[1];
      fill_full  = m_fill ? fo1 : fo0;
      other_full = m_fill ? fo0 : fo1;
      if (!fill_full) begin
        for (int i = 0; i < N; i++) begin
          if (hif.hidden_valid[i]) begin
            if (m_mask[m_fill][i]) m_ovf = 1'b1;
            else begin
              m_mask[m_fill][i] = 1'b1;
              m_data[m_fill][i] = hif.hidden_out[i*IW +: IW];
            end
          end
        end
        if (&m_mask[m_fill]) begin
          // Frame complete: first word two cycles later, or after the
          // previous frame's stream + gap + idle cycle.
          start = (cyc + 2 > next_start) ? cyc + 2 : next_start;
          for (int j = 0; j < N; j++) begin
            w.cyc  = start + j;
            w.data = DW'(int'(m_data[m_fill][j]) * (2 ** SH));
            w.last = (j == N - 1);
            exp_q.push_back(w);
          end
          free_at[m_fill] = start + N - 1;
          win_s.push_back(start);
          win_e.push_back(start + N - 1 + GAP);
          next_start = start + N - 1 + GAP + 2;
          m_full[m_fill] = 1'b1;
        end
      end else if (|hif.hidden_valid) begin
        m_ovf = 1'b1;
      end
      if (fill_full && !other_full) m_fill = !m_fill;
      if (fo0 && free_at[0] == cyc) begin m_full[0] = 1'b0; m_mask[0] = '0; end
      if (fo1 && free_at[1] == cyc) begin m_full[1] = 1'b0; m_mask[1] = '0; end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin : cmp
    word_t         w;
    bit            ev, el, eb, inwin;
    logic [DW-1:0] ed;
    if (started) begin
      ev = 1'b0; el = 1'b0; ed = '0;
      while (win_e.size() > 0 && win_e[0] < cyc) begin
        void'(win_s.pop_front());
        void'(win_e.pop_front());
      end
      inwin = 1'b0;
      for (int k = 0; k < win_s.size(); k++)
        if (cyc >= win_s[k] && cyc <= win_e[k]) inwin = 1'b1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        w  = exp_q.pop_front();
        ev = 1'b1; ed = w.data; el = w.last;
      end
      eb = m_full[0] | m_full[1] | (|m_mask[m_fill]) | inwin;
      check("stream_valid", hif.stream_valid, ev);
      check("stream_data",  hif.stream_data,  ed);
      check("stream_last",  hif.stream_last,  el);
      check("busy",         busy,             eb);
      check("overflow",     overflow,         m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] t1_exp [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  int          ord    [4] = '{2, 0, 3, 1};

  initial begin
    hif.hidden_valid = '0;
    hif.hidden_out   = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", hif.stream_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);

    // All neurons in one cycle.
    hif.hidden_out   = {8'h40, 8'h30, 8'h20, 8'h10};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    @(negedge clk);
    check("t1_latency", hif.stream_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      check("t1_valid", hif.stream_valid, 1'b1);
      check("t1_data", hif.stream_data, t1_exp[j]);
      check("t1_last", hif.stream_last, (j == 3));
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      @(negedge clk);
      check("t1_gap", hif.stream_valid, 1'b0);
    end

    // Staggered neurons 2,0,3,1.
    for (int k = 0; k < 4; k++) begin
      hif.hidden_valid = '0;
      hif.hidden_valid[ord[k]] = 1'b1;
      hif.hidden_out[ord[k]*IW +: IW] = 8'hFF;
      tick();
      if (k == 0) begin
        @(negedge clk);
        check("t2_busy_partial", busy, 1'b1);
      end
    end
    hif.hidden_valid = '0;
    @(negedge clk);
    check("t2_latency", hif.stream_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      check("t2_valid", hif.stream_valid, 1'b1);
      check("t2_data", hif.stream_data, 16'h0FF0);
    end
    check("t2_overflow", overflow, 1'b0);
    repeat (6) tick();

    // Two back-to-back frames, then a third while both banks are full.
    hif.hidden_out = {4{8'hA5}};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    tick();
    tick();
    hif.hidden_out = {4{8'h5A}};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    @(negedge clk);
    check("t3_no_overflow", overflow, 1'b0);
    tick();
    hif.hidden_out = {4{8'h33}};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    @(negedge clk);
    check("t4_overflow", overflow, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    check("t3_idle_before_b", hif.stream_valid, 1'b0);
    tick();
    @(negedge clk);
    check("t3_b_valid", hif.stream_valid, 1'b1);
    check("t3_b_data", hif.stream_data, 16'h05A0);
    repeat (20) tick();
    @(negedge clk);
    check("t4_overflow_sticky", overflow, 1'b1);
    check("t4_drained_busy", busy, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_clears_overflow", overflow, 1'b0);

    // Duplicate valid on neuron 0.
    hif.hidden_out = {4{8'h11}};
    hif.hidden_valid = 4'h1;
    tick();
    hif.hidden_out = {4{8'h22}};
    tick();
    @(negedge clk);
    check("t5_overflow", overflow, 1'b1);
    hif.hidden_out = {8'h44, 8'h44, 8'h44, 8'h00};
    hif.hidden_valid = 4'hE;
    tick();
    hif.hidden_valid = '0;
    tick();
    @(negedge clk);
    check("t5_valid", hif.stream_valid, 1'b1);
    check("t5_first_word", hif.stream_data, 16'h0110);
    repeat (10) tick();

    // Reset in the second stream cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hif.hidden_out = {4{8'h77}};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    tick();
    tick();
    @(negedge clk);
    check("t6_streaming", hif.stream_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid_low", hif.stream_valid, 1'b0);
    check("t6_busy_low", busy, 1'b0);
    check("t6_overflow_low", overflow, 1'b0);
    hif.hidden_out = {4{8'h12}};
    hif.hidden_valid = 4'hF;
    tick();
    hif.hidden_valid = '0;
    tick();
    @(negedge clk);
    check("t6_fresh_valid", hif.stream_valid, 1'b1);
    check("t6_fresh_data", hif.stream_data, 16'h0120);
    repeat (10) tick();

    // Randomized frames with staggered firing, duplicates and collisions.
    for (int f = 0; f < 250; f++) begin
      int ft [N];
      int dupn, dupt;
      logic [N-1:0] v;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      for (int i = 0; i < N; i++) ft[i] = $urandom_range(0, 4);
      dupn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      dupt = $urandom_range(0, 5);
      for (int t = 0; t < 6; t++) begin
        v = '0;
        for (int i = 0; i < N; i++)
          if (ft[i] == t || (i == dupn && t == dupt)) v[i] = 1'b1;
        hif.hidden_valid = v;
        hif.hidden_out   = (N*IW)'($urandom);
        tick();
      end
      hif.hidden_valid = '0;
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
